// File: rtl/apb_demux_timeout.sv
// ----------------------------------------------------------------------------
// apb_demux_timeout
//   Registered APB demultiplexer. One upstream APB port is routed to one of
//   N_SLV downstream peripherals by address range. Unmapped addresses are
//   answered locally with an error, hung slaves are aborted after a
//   programmable number of ACCESS cycles, and error/timeout status is exposed
//   for the SoC control registers.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   s_p*                     upstream APB slave port (from the AXI-to-APB bridge)
//   m_p*                     downstream APB master port (psel per slave, rest shared)
//   clr_status_i             synchronous clear of timeout_o and both counters
//   timeout_o                sticky flag: a timeout occurred since last clear
//   timeout_cnt_o            saturating count of timeouts
//   decerr_cnt_o             saturating count of decode errors
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for an upstream SETUP phase
// SETUP  | downstream SETUP phase (psel=1, penable=0), timer loaded
// ACCESS | downstream ACCESS phase, waiting for pready or timer expiry
// RESP   | upstream pready with the registered response
// DECERR | upstream pready with pslverr for an unmapped address
// ----------------------------------------------------------------------------
module apb_demux_timeout #(
    parameter int unsigned N_SLV          = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0] ADDR_BEGIN = '0,
    parameter logic [N_SLV-1:0][ADDR_WIDTH-1:0] ADDR_END   = '0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        s_psel_i,
    input  logic                        s_penable_i,
    input  logic                        s_pwrite_i,
    input  logic [ADDR_WIDTH-1:0]       s_paddr_i,
    input  logic [DATA_WIDTH-1:0]       s_pwdata_i,
    output logic [DATA_WIDTH-1:0]       s_prdata_o,
    output logic                        s_pready_o,
    output logic                        s_pslverr_o,
    output logic [N_SLV-1:0]            m_psel_o,
    output logic                        m_penable_o,
    output logic                        m_pwrite_o,
    output logic [ADDR_WIDTH-1:0]       m_paddr_o,
    output logic [DATA_WIDTH-1:0]       m_pwdata_o,
    input  logic [N_SLV*DATA_WIDTH-1:0] m_prdata_i,
    input  logic [N_SLV-1:0]            m_pready_i,
    input  logic [N_SLV-1:0]            m_pslverr_i,
    input  logic                        clr_status_i,
    output logic                        timeout_o,
    output logic [7:0]                  timeout_cnt_o,
    output logic [7:0]                  decerr_cnt_o
);

    localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter: loaded in SETUP so that ACCESS lasts at most
    // TIMEOUT_CYCLES cycles; expiry is the cycle it reads zero.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_DECERR
    } state_t;

    state_t                  state_q, state_d;
    logic                    req;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic [TMR_W-1:0]        timer_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    ready_evt;
    logic                    timeout_evt;
    logic                    decerr_evt;

    assign req = s_psel_i & ~s_penable_i;

    // Address decode; scanning downwards lets the lowest index win on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((s_paddr_i >= ADDR_BEGIN[k]) && (s_paddr_i <= ADDR_END[k])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // Response mux from the selected slave.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = m_pready_i[k];
                sel_err   = m_pslverr_i[k];
                sel_rdata = m_prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_evt   = 1'b0;
        timeout_evt = 1'b0;
        decerr_evt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = hit ? ST_SETUP : ST_DECERR;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Ready in the expiry cycle still completes normally.
                if (sel_ready) begin
                    ready_evt = 1'b1;
                    state_d   = ST_RESP;
                end else if (timer_q == '0) begin
                    timeout_evt = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_DECERR: begin
                decerr_evt = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, timer and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            timer_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && req) begin
                idx_q   <= hit_idx;
                addr_q  <= s_paddr_i;
                wdata_q <= s_pwdata_i;
                write_q <= s_pwrite_i;
            end
            if (state_q == ST_SETUP) begin
                timer_q <= TMR_LOAD;
            end else if ((state_q == ST_ACCESS) && !sel_ready && (timer_q != '0)) begin
                timer_q <= timer_q - 1'b1;
            end
            if (ready_evt) begin
                rdata_q <= write_q ? '0 : sel_rdata;
                err_q   <= sel_err;
            end else if (timeout_evt) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Status: an event coincident with a clear survives the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_o     <= 1'b0;
            timeout_cnt_o <= '0;
            decerr_cnt_o  <= '0;
        end else if (clr_status_i) begin
            timeout_o     <= timeout_evt;
            timeout_cnt_o <= {7'd0, timeout_evt};
            decerr_cnt_o  <= {7'd0, decerr_evt};
        end else begin
            if (timeout_evt) begin
                timeout_o <= 1'b1;
                if (timeout_cnt_o != 8'hFF) begin
                    timeout_cnt_o <= timeout_cnt_o + 8'd1;
                end
            end
            if (decerr_evt && (decerr_cnt_o != 8'hFF)) begin
                decerr_cnt_o <= decerr_cnt_o + 8'd1;
            end
        end
    end

    always_comb begin
        m_psel_o = '0;
        if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
            for (int k = 0; k < N_SLV; k++) begin
                m_psel_o[k] = (idx_q == IDX_W'(k));
            end
        end
    end

    assign m_penable_o = (state_q == ST_ACCESS);
    assign m_pwrite_o  = write_q;
    assign m_paddr_o   = addr_q;
    assign m_pwdata_o  = wdata_q;

    assign s_pready_o  = (state_q == ST_RESP) || (state_q == ST_DECERR);
    assign s_pslverr_o = ((state_q == ST_RESP) && err_q) || (state_q == ST_DECERR);
    assign s_prdata_o  = (state_q == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_demux_timeout.sv
module tb_apb_demux_timeout;

    localparam int T = 16;
    localparam logic [1:0][31:0] BEG  = {32'h1A10_4000, 32'h1A10_3000};
    localparam logic [1:0][31:0] ENDA = {32'h1A10_4FFF, 32'h1A10_3FFF};

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        s_psel_i = 1'b0;
    logic        s_penable_i = 1'b0;
    logic        s_pwrite_i = 1'b0;
    logic [31:0] s_paddr_i = '0;
    logic [31:0] s_pwdata_i = '0;
    logic [31:0] s_prdata_o;
    logic        s_pready_o;
    logic        s_pslverr_o;
    logic [1:0]  m_psel_o;
    logic        m_penable_o;
    logic        m_pwrite_o;
    logic [31:0] m_paddr_o;
    logic [31:0] m_pwdata_o;
    logic [63:0] m_prdata_i;
    logic [1:0]  m_pready_i = '0;
    logic [1:0]  m_pslverr_i;
    logic        clr_status_i = 1'b0;
    logic        timeout_o;
    logic [7:0]  timeout_cnt_o;
    logic [7:0]  decerr_cnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural slave configuration
    int          s_wait [2];
    bit          s_hang [2];
    logic [31:0] s_rd   [2];
    logic        s_err  [2];
    int          acc_cnt[2];

    // Status model
    bit m_tflag = 0;
    int m_tcnt  = 0;
    int m_dcnt  = 0;

    assign m_prdata_i  = {s_rd[1], s_rd[0]};
    assign m_pslverr_i = {s_err[1], s_err[0]};

    apb_demux_timeout #(
        .N_SLV(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ADDR_BEGIN(BEG), .ADDR_END(ENDA), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_psel_i(s_psel_i), .s_penable_i(s_penable_i), .s_pwrite_i(s_pwrite_i),
        .s_paddr_i(s_paddr_i), .s_pwdata_i(s_pwdata_i), .s_prdata_o(s_prdata_o),
        .s_pready_o(s_pready_o), .s_pslverr_o(s_pslverr_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_prdata_i(m_prdata_i),
        .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
        .clr_status_i(clr_status_i), .timeout_o(timeout_o),
        .timeout_cnt_o(timeout_cnt_o), .decerr_cnt_o(decerr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Slaves answer after s_wait wait states (ready on access cycle s_wait+1)
    always @(negedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (m_psel_o[k] && m_penable_o) begin
                acc_cnt[k] = acc_cnt[k] + 1;
                m_pready_i[k] = !s_hang[k] && (acc_cnt[k] > s_wait[k]);
            end else begin
                acc_cnt[k] = 0;
                m_pready_i[k] = 1'b0;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        bit          hang;
        logic [31:0] srd;
        logic        serr;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [1:0]  exp_psel;
    } vec_t;

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        do_check({tag, ":timeout_o"}, {31'd0, timeout_o}, {31'd0, m_tflag});
        do_check({tag, ":timeout_cnt"}, {24'd0, timeout_cnt_o}, 32'(m_tcnt));
        do_check({tag, ":decerr_cnt"}, {24'd0, decerr_cnt_o}, 32'(m_dcnt));
    endtask

    task automatic set_slaves(input int wt, input bit hang, input logic [31:0] srd, input logic serr);
        for (int k = 0; k < 2; k++) begin
            s_wait[k] = wt;
            s_hang[k] = hang;
            s_err[k]  = serr;
        end
        s_rd[0] = srd;
        s_rd[1] = srd ^ 32'hFFFF_0000;
    endtask

    // Reference: expected result from decode ranges and slave behaviour
    task automatic model(input logic wr, input logic [31:0] addr,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic [1:0] psel, output bit tmo, output bit dec);
        int slv = -1;
        for (int k = 0; k < 2; k++)
            if (slv < 0 && addr >= BEG[k] && addr <= ENDA[k]) slv = k;
        tmo = 0; dec = 0;
        if (slv < 0) begin
            rd = 0; err = 1; lat = 1; psel = 2'b00; dec = 1;
        end else begin
            psel = (slv == 0) ? 2'b01 : 2'b10;
            if (s_hang[slv] || s_wait[slv] >= T) begin
                rd = 0; err = 1; lat = T + 2; tmo = 1;
            end else begin
                lat = 3 + s_wait[slv];
                err = s_err[slv];
                rd  = wr ? 32'd0 : s_rd[slv];
            end
        end
    endtask

    // Drives one upstream transfer starting at the current negedge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int clr_at, output logic [31:0] rd, output logic err,
                        output int lat, output logic [1:0] psel_seen, output bit proto_ok);
        bit done = 0;
        int pcyc = 0;
        s_psel_i = 1; s_penable_i = 0; s_pwrite_i = wr; s_paddr_i = addr; s_pwdata_i = wdata;
        proto_ok = 1; psel_seen = 0; lat = -1; rd = 0; err = 0;
        for (int n = 1; n <= 100 && !done; n++) begin
            @(negedge clk_i);
            clr_status_i = (n == clr_at);
            s_penable_i = 1;
            if (|m_psel_o) begin
                psel_seen |= m_psel_o;
                pcyc++;
                if (m_paddr_o !== addr || m_pwdata_o !== wdata || m_pwrite_o !== wr) proto_ok = 0;
                if (m_penable_o !== (pcyc > 1)) proto_ok = 0;
            end
            if (s_pready_o) begin
                done = 1; lat = n; rd = s_prdata_o; err = s_pslverr_o;
                if (|m_psel_o) proto_ok = 0;
            end else if (s_pslverr_o !== 1'b0 || s_prdata_o !== 32'd0) begin
                proto_ok = 0;
            end
        end
        s_psel_i = 0; s_penable_i = 0; clr_status_i = 0;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int clr_at,
                       input logic [31:0] e_rd, input logic e_err, input int e_lat,
                       input logic [1:0] e_psel, input bit tmo, input bit dec);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [1:0]  ps;
        bit          ok;
        @(negedge clk_i);
        check_status(tag);
        xfer(wr, addr, wdata, clr_at, rd, err, lat, ps, ok);
        do_check({tag, ":rdata"}, rd, e_rd);
        do_check({tag, ":pslverr"}, {31'd0, err}, {31'd0, e_err});
        do_check({tag, ":latency"}, 32'(lat), 32'(e_lat));
        do_check({tag, ":psel"}, {30'd0, ps}, {30'd0, e_psel});
        do_check({tag, ":protocol"}, {31'd0, ok}, 32'd1);
        if (clr_at >= 0) begin
            m_tflag = tmo; m_tcnt = tmo ? 1 : 0; m_dcnt = dec ? 1 : 0;
        end else begin
            if (tmo) begin
                m_tflag = 1;
                if (m_tcnt < 255) m_tcnt++;
            end
            if (dec && m_dcnt < 255) m_dcnt++;
        end
    endtask

    task automatic model_txn(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int clr_at);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [1:0]  ps;
        bit          tmo, dec;
        model(wr, addr, rd, err, lat, ps, tmo, dec);
        txn(tag, wr, addr, wdata, clr_at, rd, err, lat, ps, tmo, dec);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 32'h1A10_3004, 32'h0,    0,  0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 3,  2'b01};
        vecs[1] = '{1'b1, 32'h1A10_4010, 32'h55,   3,  0, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 6,  2'b10};
        vecs[2] = '{1'b0, 32'h1A10_5000, 32'h0,    0,  0, 32'h1,         1'b0, 32'h0,         1'b1, 1,  2'b00};
        vecs[3] = '{1'b0, 32'h1A10_4FFC, 32'h0,    0,  0, 32'h0000_1234, 1'b1, 32'hFFFF_1234, 1'b1, 3,  2'b10};
        vecs[4] = '{1'b0, 32'h1A10_3000, 32'h0,    0,  1, 32'h5,         1'b0, 32'h0,         1'b1, 18, 2'b01};
        vecs[5] = '{1'b0, 32'h1A10_4000, 32'h0,    0,  0, 32'h0000_CAFE, 1'b0, 32'hFFFF_CAFE, 1'b0, 3,  2'b10};
        vecs[6] = '{1'b0, 32'h1A10_3FFF, 32'h0,    15, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 18, 2'b01};
        vecs[7] = '{1'b0, 32'h1A10_2FFF, 32'h0,    0,  0, 32'h7,         1'b0, 32'h0,         1'b1, 1,  2'b00};
        vecs[8] = '{1'b1, 32'h1A10_3100, 32'hA5A5, 16, 0, 32'h9,         1'b0, 32'h0,         1'b1, 18, 2'b01};
        vecs[9] = '{1'b1, 32'h1A10_4004, 32'h77,   1,  0, 32'h7777_7777, 1'b1, 32'h0,         1'b1, 4,  2'b10};

        set_slaves(0, 0, 32'h0, 1'b0);
        repeat (3) @(negedge clk_i);
        do_check("reset:psel", {30'd0, m_psel_o}, 32'd0);
        do_check("reset:penable", {31'd0, m_penable_o}, 32'd0);
        do_check("reset:pready", {31'd0, s_pready_o}, 32'd0);
        do_check("reset:pslverr", {31'd0, s_pslverr_o}, 32'd0);
        do_check("reset:prdata", s_prdata_o, 32'd0);
        check_status("reset");
        rst_ni = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            bit tmo, dec;
            set_slaves(vecs[i].wt, vecs[i].hang, vecs[i].srd, vecs[i].serr);
            dec = (vecs[i].exp_psel == 2'b00);
            tmo = !dec && vecs[i].exp_err && (vecs[i].hang || vecs[i].wt >= T);
            txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, -1,
                vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_psel, tmo, dec);
        end

        // Randomized transfers against the model
        for (int i = 0; i < 80; i++) begin
            logic [31:0] addr;
            int sel = $urandom_range(0, 5);
            case (sel)
                0, 1: addr = 32'h1A10_3000 + ($urandom_range(0, 32'hFFF));
                2, 3: addr = 32'h1A10_4000 + ($urandom_range(0, 32'hFFF));
                4:    addr = ($urandom_range(0, 1) == 0) ? 32'h1A10_5000 + $urandom_range(0, 255) : 32'h0000_0100;
                default: addr = ($urandom_range(0, 1) == 0) ? 32'h1A10_2FFF : 32'h1A10_4FFF;
            endcase
            set_slaves(($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 4)),
                       ($urandom_range(0, 9) == 0), $urandom, $urandom_range(0, 3) == 0);
            model_txn($sformatf("rnd%0d", i), $urandom_range(0, 1) == 1, addr, $urandom, -1);
        end

        // Timeout, then clear coincident with the next timeout event
        set_slaves(0, 1, 32'h0, 1'b0);
        model_txn("tmo_a", 1'b0, 32'h1A10_3008, 32'h0, -1);
        model_txn("tmo_clr", 1'b0, 32'h1A10_300C, 32'h0, T + 1);
        set_slaves(0, 0, 32'h1357_9BDF, 1'b0);
        model_txn("after_tmo", 1'b0, 32'h1A10_4020, 32'h0, -1);

        // Saturation of the decode-error counter, then a plain clear
        for (int i = 0; i < 300; i++)
            model_txn("decerr_sat", 1'b0, 32'h1A10_6000, 32'h0, -1);
        @(negedge clk_i);
        check_status("sat");
        do_check("sat:value", {24'd0, decerr_cnt_o}, 32'hFF);
        clr_status_i = 1'b1;
        @(negedge clk_i);
        clr_status_i = 1'b0;
        m_tflag = 0; m_tcnt = 0; m_dcnt = 0;
        check_status("clr");

        // Reset asserted during ACCESS
        set_slaves(5, 0, 32'h2468_ACE0, 1'b0);
        @(negedge clk_i);
        s_psel_i = 1; s_penable_i = 0; s_pwrite_i = 0; s_paddr_i = 32'h1A10_3010;
        @(negedge clk_i);
        s_penable_i = 1;
        @(negedge clk_i);
        do_check("mid_rst:access_psel", {30'd0, m_psel_o}, 32'd1);
        do_check("mid_rst:access_penable", {31'd0, m_penable_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        do_check("mid_rst:psel", {30'd0, m_psel_o}, 32'd0);
        do_check("mid_rst:penable", {31'd0, m_penable_o}, 32'd0);
        do_check("mid_rst:pready", {31'd0, s_pready_o}, 32'd0);
        s_psel_i = 0; s_penable_i = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_tflag = 0; m_tcnt = 0; m_dcnt = 0;
        set_slaves(0, 0, 32'hDEAD_BEEF, 1'b0);
        model_txn("post_rst", 1'b0, 32'h1A10_3004, 32'h0, -1);

        @(negedge clk_i);
        check_status("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
